// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control blocks.
// Contents: state encoding constants, the FSM state type, and the default miss timeout.
// No ports; imported by the stall controller and its interface.
package cpu_ctrl_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam int DEFAULT_MISS_TIMEOUT = 255;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    MISS  = ST_MISS,
    ERROR = ST_ERROR
  } ctrlStateT;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundles the hazard inputs and the pipeline-register controls of pipeline_stall_ctrl.
// Ports: hazard/dcache inputs (ld_use_i, branch_taken_i, dcache_*), per-stage controls,
// error flag and the two CNT_W-wide performance counters. slave = controller side.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             ld_use_i;
  logic             branch_taken_i;
  logic             dcache_req_i;
  logic             dcache_hit_i;
  logic             dcache_ack_i;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_bubble_o;
  logic             ex_mem_hold_o;
  logic             mem_wb_bubble_o;
  logic             error_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output ld_use_i, branch_taken_i, dcache_req_i, dcache_hit_i, dcache_ack_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           ex_mem_hold_o, mem_wb_bubble_o, error_o, stall_cycles_o, flush_cnt_o
  );

  modport slave (
    input  ld_use_i, branch_taken_i, dcache_req_i, dcache_hit_i, dcache_ack_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           ex_mem_hold_o, mem_wb_bubble_o, error_o, stall_cycles_o, flush_cnt_o
  );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports: clk_i, rst_i (sync, active-high), inc_i (count this cycle), cnt_o (W bits).
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges load-use, branch-taken and dcache-miss into
// per-stage write-enables, flushes and bubbles (Mealy outputs, same-cycle effect).
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport); freezes the pipe during misses.
module pipeline_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = DEFAULT_MISS_TIMEOUT,
  parameter int CNT_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_stall_ctrl_if.slave  bus
);

  // Last miss_cnt value tolerated before a missing ack is declared a hang.
  localparam logic [7:0] MISS_LIMIT = 8'(MISS_TIMEOUT - 1);

  ctrlStateT  state;
  ctrlStateT  stateNxt;
  logic [7:0] missCnt;
  logic [7:0] missCntNxt;

  logic pcWrite;
  logic ifIdWrite;
  logic ifIdFlush;
  logic idExBubble;
  logic exMemHold;
  logic memWbBubble;
  logic freeze;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RUN;
      missCnt <= 8'd0;
    end else begin
      state   <= stateNxt;
      missCnt <= missCntNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    missCntNxt  = missCnt;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    exMemHold   = 1'b0;
    memWbBubble = 1'b0;
    freeze      = 1'b0;

    case (state)
      RUN: begin
        if (bus.dcache_req_i && !bus.dcache_hit_i) begin
          freeze     = 1'b1;
          stateNxt   = MISS;
          missCntNxt = 8'd0;
        end else if (bus.ld_use_i) begin
          // A branch seen alongside a load-use is not flushed: ID is held,
          // so the branch resolves again next cycle.
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExBubble = 1'b1;
        end else if (bus.branch_taken_i) begin
          ifIdFlush = 1'b1;
        end
      end
      MISS: begin
        // The ack cycle is still frozen; the replayed access hits in RUN.
        freeze = 1'b1;
        if (bus.dcache_ack_i) begin
          stateNxt = RUN;
        end else if (missCnt == MISS_LIMIT) begin
          stateNxt = ERROR;
        end else begin
          missCntNxt = missCnt + 8'd1;
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        stateNxt = RUN;
      end
    endcase

    if (freeze) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      exMemHold   = 1'b1;
      memWbBubble = 1'b1;
    end

    // Reset quiets every control, including the write-enables.
    if (rst_i) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      ifIdFlush   = 1'b0;
      idExBubble  = 1'b0;
      exMemHold   = 1'b0;
      memWbBubble = 1'b0;
    end
  end

  assign bus.pc_write_o      = pcWrite;
  assign bus.if_id_write_o   = ifIdWrite;
  assign bus.if_id_flush_o   = ifIdFlush;
  assign bus.id_ex_bubble_o  = idExBubble;
  assign bus.ex_mem_hold_o   = exMemHold;
  assign bus.mem_wb_bubble_o = memWbBubble;
  assign bus.error_o         = (state == ERROR);

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!pcWrite),
    .cnt_o (bus.stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ifIdFlush),
    .cnt_o (bus.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: two instances (default parameters, and
// MISS_TIMEOUT=4 / CNT_W=4) share one stimulus stream; a reference model predicts
// each cycle's outputs into queues that an independent monitor pops and compares.
module tb_pipeline_stall_ctrl;

  logic clk;
  logic rst;

  pipeline_stall_ctrl_if #(.CNT_W(32)) busA ();
  pipeline_stall_ctrl_if #(.CNT_W(4))  busB ();

  pipeline_stall_ctrl #(.MISS_TIMEOUT(255), .CNT_W(32)) dutA (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busA)
  );

  pipeline_stall_ctrl #(.MISS_TIMEOUT(4), .CNT_W(4)) dutB (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     pcW;
    bit     ifW;
    bit     fl;
    bit     bub;
    bit     hold;
    bit     mwb;
    bit     err;
    longint stall;
    longint flc;
  } expT;

  expT expA[$];
  expT expB[$];

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  // Behavioural view of each instance: is a miss outstanding, how long has it
  // been waiting, has it hung, and how many stall / flush cycles were seen.
  bit     inMiss[2];
  bit     hung[2];
  int     missCycles[2];
  longint stallCnt[2];
  longint flushCnt[2];
  int     timeout[2] = '{255, 4};
  longint cntMax[2]  = '{64'h0000_0000_FFFF_FFFF, 64'd15};

  task automatic predict(input int k, input bit r, input bit ld, input bit br,
                         input bit req, input bit hit, input bit ack, output expT e);
    bit frz;
    frz    = 1'b0;
    e.pcW  = 1'b1;
    e.ifW  = 1'b1;
    e.fl   = 1'b0;
    e.bub  = 1'b0;
    e.hold = 1'b0;
    e.mwb  = 1'b0;
    e.err  = hung[k];
    e.stall = stallCnt[k];
    e.flc   = flushCnt[k];
    if (r) begin
      e.pcW = 1'b0;
      e.ifW = 1'b0;
      inMiss[k]   = 1'b0;
      hung[k]     = 1'b0;
      stallCnt[k] = 0;
      flushCnt[k] = 0;
    end else begin
      if (hung[k]) begin
        frz = 1'b1;
      end else if (inMiss[k]) begin
        frz = 1'b1;
        missCycles[k]++;
        if (ack) inMiss[k] = 1'b0;
        else if (missCycles[k] >= timeout[k]) begin
          inMiss[k] = 1'b0;
          hung[k]   = 1'b1;
        end
      end else if (req && !hit) begin
        frz = 1'b1;
        inMiss[k]     = 1'b1;
        missCycles[k] = 0;
      end else if (ld) begin
        e.pcW = 1'b0;
        e.ifW = 1'b0;
        e.bub = 1'b1;
      end else if (br) begin
        e.fl = 1'b1;
      end
      if (frz) begin
        e.pcW  = 1'b0;
        e.ifW  = 1'b0;
        e.hold = 1'b1;
        e.mwb  = 1'b1;
      end
      if (!e.pcW && stallCnt[k] < cntMax[k]) stallCnt[k]++;
      if (e.fl && flushCnt[k] < cntMax[k]) flushCnt[k]++;
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input bit br, input bit req,
                     input bit hit, input bit ack);
    expT e;
    @(posedge clk);
    #1;
    rst = r;
    busA.ld_use_i = ld;  busA.branch_taken_i = br;  busA.dcache_req_i = req;
    busA.dcache_hit_i = hit;  busA.dcache_ack_i = ack;
    busB.ld_use_i = ld;  busB.branch_taken_i = br;  busB.dcache_req_i = req;
    busB.dcache_hit_i = hit;  busB.dcache_ack_i = ack;
    predict(0, r, ld, br, req, hit, ack, e);
    expA.push_back(e);
    predict(1, r, ld, br, req, hit, ack, e);
    expB.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, so each negedge consumes one prediction.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (expA.size() > 0) begin
        e = expA.pop_front();
        chk("A.pc_write",   busA.pc_write_o,      e.pcW);
        chk("A.if_id_write", busA.if_id_write_o,  e.ifW);
        chk("A.flush",      busA.if_id_flush_o,   e.fl);
        chk("A.bubble",     busA.id_ex_bubble_o,  e.bub);
        chk("A.hold",       busA.ex_mem_hold_o,   e.hold);
        chk("A.mwb_bubble", busA.mem_wb_bubble_o, e.mwb);
        chk("A.error",      busA.error_o,         e.err);
        chk("A.stall_cnt",  busA.stall_cycles_o,  e.stall);
        chk("A.flush_cnt",  busA.flush_cnt_o,     e.flc);
      end
      if (expB.size() > 0) begin
        e = expB.pop_front();
        chk("B.pc_write",   busB.pc_write_o,      e.pcW);
        chk("B.if_id_write", busB.if_id_write_o,  e.ifW);
        chk("B.flush",      busB.if_id_flush_o,   e.fl);
        chk("B.bubble",     busB.id_ex_bubble_o,  e.bub);
        chk("B.hold",       busB.ex_mem_hold_o,   e.hold);
        chk("B.mwb_bubble", busB.mem_wb_bubble_o, e.mwb);
        chk("B.error",      busB.error_o,         e.err);
        chk("B.stall_cnt",  busB.stall_cycles_o,  e.stall);
        chk("B.flush_cnt",  busB.flush_cnt_o,     e.flc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    busA.ld_use_i = 0; busA.branch_taken_i = 0; busA.dcache_req_i = 0;
    busA.dcache_hit_i = 0; busA.dcache_ack_i = 0;
    busB.ld_use_i = 0; busB.branch_taken_i = 0; busB.dcache_req_i = 0;
    busB.dcache_hit_i = 0; busB.dcache_ack_i = 0;
    repeat (2) @(posedge clk);

    // Reset held, then idle run.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Single load-use stall.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Load-use suppresses a simultaneous branch; the branch then flushes alone.
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Miss acked on the 3rd MISS cycle, then the replay hits.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Hazards toggling during a miss must not leak through.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Hung miss: both instances reach ERROR; stray acks afterwards are ignored.
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 258; i++) cyc(0, i[0], i[1], 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // Twenty stalls push the 4-bit counter into saturation.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("drainA", expA.size(), 0);
    chk("drainB", expB.size(), 0);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipelined CPU. Merges the load-use hazard flag, the ID-stage branch-taken signal and the data-cache miss handshake into one consistent set of per-stage write-enables, flushes and bubbles. Holds the whole pipeline frozen for the duration of a cache miss, and detects hung misses. Sits beside the hazard detection unit and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls.

## Interface
Parameters:
- MISS_TIMEOUT, 255: max MISS cycles without ack before entering ERROR; legal range 1..255.
- CNT_W, 32: width of performance counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- ld_use_i  in  1  load-use hazard from the hazard detection unit; 1 = stall required.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- dcache_req_i  in  1  MEM stage issues a load/store this cycle.
- dcache_hit_i  in  1  qualifies dcache_req_i; 0 with req = miss.
- dcache_ack_i  in  1  miss fill complete; meaningful only in MISS.
- pc_write_o  out  1  1 = PC updates.
- if_id_write_o  out  1  1 = IF/ID register loads.
- if_id_flush_o  out  1  1 = IF/ID loaded with NOP.
- id_ex_bubble_o  out  1  1 = ID/EX control bits zeroed.
- ex_mem_hold_o  out  1  1 = EX/MEM and ID/EX hold their contents.
- mem_wb_bubble_o  out  1  1 = MEM/WB control bits zeroed.
- error_o  out  1  sticky miss-timeout error.
- stall_cycles_o  out  CNT_W  cycles with pc_write_o = 0, saturating.
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o = 1, saturating.

## Operation
- States: RUN, MISS, ERROR. Reset state RUN.
- Outputs are Mealy: combinational from the current state and the current inputs. Stalls therefore take effect in the same cycle as the hazard.
- RUN, priority miss > load-use > branch:
  - Miss (dcache_req_i=1, dcache_hit_i=0): full freeze this cycle. pc_write_o=0, if_id_write_o=0, ex_mem_hold_o=1, mem_wb_bubble_o=1, id_ex_bubble_o=0, if_id_flush_o=0. Next state MISS; miss_cnt cleared to 0.
  - Else ld_use_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1. if_id_flush_o=0 even when branch_taken_i=1; the branch re-resolves next cycle.
  - Else branch_taken_i=1: if_id_flush_o=1 with all write-enables at 1.
  - Else: pc_write_o=1, if_id_write_o=1, all others 0.
- MISS:
  - Full freeze as above, independent of ld_use_i and branch_taken_i.
  - The ack cycle is itself still frozen.
  - dcache_ack_i=1: next state RUN, where the replayed access hits.
  - Otherwise miss_cnt increments. When miss_cnt reaches MISS_TIMEOUT-1 without an ack, next state is ERROR.
- ERROR: full freeze, error_o=1. Exit only via rst_i.
- Counters: 8-bit miss_cnt. stall_cycles_o and flush_cnt_o saturate at all-ones and never wrap.

## Timing
- While rst_i=1: pc_write_o=0, if_id_write_o=0, all flush/bubble/hold outputs 0. Cycle after deassertion: state RUN, error_o=0, counters 0.
- Reset during MISS or ERROR returns to RUN on the next edge; any pending ack is ignored.
- Load-use stall lasts exactly one cycle per ld_use_i assertion cycle. No internal state is involved.
- Miss latency: freeze cycles = 1 (detect) + N (MISS cycles, including the ack cycle). Ack on the first MISS cycle gives 2 frozen cycles total.
- dcache_ack_i in RUN or ERROR is ignored.
- Counters update on the edge after the cycle they count. Reads are combinational from registers.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state encoding localparams ST_RUN=2'd0, ST_MISS=2'd1, ST_ERROR=2'd2;
  - the default MISS_TIMEOUT.
- One natural sub-module, sat_counter (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o), instantiated twice for the performance counters.

## Test plan
- ld_use_i=1 for one cycle in RUN → pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 that cycle only; stall_cycles_o=1 afterwards.
- ld_use_i=1 and branch_taken_i=1 in the same cycle → if_id_flush_o=0, stall outputs asserted; next cycle branch_taken_i=1 alone → if_id_flush_o=1, flush_cnt_o=1.
- Miss, then ack on the 3rd MISS cycle → 4 frozen cycles with ex_mem_hold_o=1 and mem_wb_bubble_o=1, then RUN; stall_cycles_o=4.
- Miss with ld_use_i and branch_taken_i toggling during MISS → outputs stay full-freeze; no flush is counted.
- MISS_TIMEOUT=4, no ack → ERROR after the 4th MISS cycle, error_o=1 sticky; rst_i=1 for one cycle → RUN, error_o=0, counters 0.
- Force stall_cycles_o near all-ones with CNT_W=4 and 20 stall cycles → output holds at 15.
